// File: rtl/exe_mem_stage_reg.sv
// EXE/MEM pipeline register with the architectural NZCV status register.
// Supplies the carry and a combinational condition-check result back to ID/EXE.
module exe_mem_stage_reg #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      freeze,
    input  logic                      flush,
    input  logic                      valid_in,
    input  logic                      s_in,
    input  logic                      wb_en_in,
    input  logic                      mem_r_en_in,
    input  logic                      mem_w_en_in,
    input  logic [DATA_WIDTH-1:0]     alu_res_in,
    input  logic [3:0]                status_bits_in,
    input  logic [DATA_WIDTH-1:0]     val_rm_in,
    input  logic [REG_ADDR_WIDTH-1:0] dest_in,
    input  logic [3:0]                cond_in,
    output logic                      valid_out,
    output logic                      wb_en,
    output logic                      mem_r_en,
    output logic                      mem_w_en,
    output logic [DATA_WIDTH-1:0]     alu_res,
    output logic [DATA_WIDTH-1:0]     val_rm,
    output logic [REG_ADDR_WIDTH-1:0] dest,
    output logic [3:0]                status_reg,
    output logic                      carry,
    output logic                      cond_pass
);

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    logic live;
    logic flag_z;
    logic flag_c;
    logic flag_n;
    logic flag_v;

    // An instruction only has architectural effect if it is real and not killed.
    assign live = valid_in & ~flush;

    // Pipeline register; freeze holds everything, including the flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_out  <= 1'b0;
            wb_en      <= 1'b0;
            mem_r_en   <= 1'b0;
            mem_w_en   <= 1'b0;
            alu_res    <= '0;
            val_rm     <= '0;
            dest       <= '0;
            status_reg <= 4'b0000;
        end else if (!freeze) begin
            valid_out <= live;
            wb_en     <= wb_en_in & live;
            mem_r_en  <= mem_r_en_in & live;
            mem_w_en  <= mem_w_en_in & live;
            alu_res   <= alu_res_in;
            val_rm    <= val_rm_in;
            dest      <= dest_in;
            if (s_in && live) begin
                status_reg <= status_bits_in;
            end
        end
    end

    // Flags are packed {Z,C,N,V}.
    assign flag_z = status_reg[3];
    assign flag_c = status_reg[2];
    assign flag_n = status_reg[1];
    assign flag_v = status_reg[0];
    assign carry  = flag_c;

    // Condition check against the committed flags (no forwarding).
    always_comb begin
        cond_pass = 1'b0;
        unique case (cond_in)
            COND_EQ: cond_pass = flag_z;
            COND_NE: cond_pass = ~flag_z;
            COND_CS: cond_pass = flag_c;
            COND_CC: cond_pass = ~flag_c;
            COND_MI: cond_pass = flag_n;
            COND_PL: cond_pass = ~flag_n;
            COND_VS: cond_pass = flag_v;
            COND_VC: cond_pass = ~flag_v;
            COND_HI: cond_pass = flag_c & ~flag_z;
            COND_LS: cond_pass = ~flag_c | flag_z;
            COND_GE: cond_pass = (flag_n == flag_v);
            COND_LT: cond_pass = (flag_n != flag_v);
            COND_GT: cond_pass = ~flag_z & (flag_n == flag_v);
            COND_LE: cond_pass = flag_z | (flag_n != flag_v);
            COND_AL: cond_pass = 1'b1;
            default: cond_pass = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_exe_mem_stage_reg.sv
// Bench for exe_mem_stage_reg: directed steps then randomized traffic,
// checked against a behavioural model of the pipeline register and flags.
module tb_exe_mem_stage_reg;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic        valid_in;
    logic        s_in;
    logic        wb_en_in;
    logic        mem_r_en_in;
    logic        mem_w_en_in;
    logic [31:0] alu_res_in;
    logic [3:0]  status_bits_in;
    logic [31:0] val_rm_in;
    logic [3:0]  dest_in;
    logic [3:0]  cond_in;
    logic        valid_out;
    logic        wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [3:0]  dest;
    logic [3:0]  status_reg;
    logic        carry;
    logic        cond_pass;

    int checks = 0;
    int errors = 0;

    // Reference state
    bit        m_valid, m_wb, m_mr, m_mw;
    bit [31:0] m_alu, m_rm;
    bit [3:0]  m_dest, m_st;

    exe_mem_stage_reg #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .valid_in(valid_in), .s_in(s_in), .wb_en_in(wb_en_in),
        .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
        .alu_res_in(alu_res_in), .status_bits_in(status_bits_in),
        .val_rm_in(val_rm_in), .dest_in(dest_in), .cond_in(cond_in),
        .valid_out(valid_out), .wb_en(wb_en), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .alu_res(alu_res), .val_rm(val_rm),
        .dest(dest), .status_reg(status_reg), .carry(carry),
        .cond_pass(cond_pass)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    // Condition semantics written out by mnemonic from the flag meanings.
    function automatic bit ref_cond(input int cc, input bit [3:0] f);
        bit z, c, n, v;
        z = f[3]; c = f[2]; n = f[1]; v = f[0];
        case (cc)
            0:  return z;
            1:  return !z;
            2:  return c;
            3:  return !c;
            4:  return n;
            5:  return !n;
            6:  return v;
            7:  return !v;
            8:  return c && !z;
            9:  return !c || z;
            10: return n == v;
            11: return n != v;
            12: return !z && (n == v);
            13: return z || (n != v);
            14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cond_is(input int cc, input bit exp, input string tag);
        cond_in = 4'(cc);
        #1;
        chk(tag, 32'(cond_pass), 32'(exp));
    endtask

    task automatic check_all();
        chk("valid_out", 32'(valid_out), 32'(m_valid));
        chk("wb_en",     32'(wb_en),     32'(m_wb));
        chk("mem_r_en",  32'(mem_r_en),  32'(m_mr));
        chk("mem_w_en",  32'(mem_w_en),  32'(m_mw));
        chk("alu_res",   alu_res,        m_alu);
        chk("val_rm",    val_rm,         m_rm);
        chk("dest",      32'(dest),      32'(m_dest));
        chk("status",    32'(status_reg), 32'(m_st));
        chk("carry",     32'(carry),     32'(m_st[2]));
        for (int cc = 0; cc < 16; cc++) begin
            cond_in = 4'(cc);
            #1;
            chk($sformatf("cond%0d", cc), 32'(cond_pass), 32'(ref_cond(cc, m_st)));
        end
    endtask

    // Advance one clock: update model from the inputs seen at the edge, then check.
    task automatic tick();
        bit        n_valid, n_wb, n_mr, n_mw;
        bit [31:0] n_alu, n_rm;
        bit [3:0]  n_dest, n_st;
        bit        real_insn;
        n_valid = m_valid; n_wb = m_wb; n_mr = m_mr; n_mw = m_mw;
        n_alu = m_alu; n_rm = m_rm; n_dest = m_dest; n_st = m_st;
        real_insn = valid_in && !flush;
        if (rst) begin
            n_valid = 0; n_wb = 0; n_mr = 0; n_mw = 0;
            n_alu = 0; n_rm = 0; n_dest = 0; n_st = 0;
        end else if (!freeze) begin
            n_valid = real_insn;
            n_wb    = real_insn && wb_en_in;
            n_mr    = real_insn && mem_r_en_in;
            n_mw    = real_insn && mem_w_en_in;
            n_alu   = alu_res_in;
            n_rm    = val_rm_in;
            n_dest  = dest_in;
            if (real_insn && s_in) n_st = status_bits_in;
        end
        @(posedge clk);
        #1;
        m_valid = n_valid; m_wb = n_wb; m_mr = n_mr; m_mw = n_mw;
        m_alu = n_alu; m_rm = n_rm; m_dest = n_dest; m_st = n_st;
        check_all();
    endtask

    task automatic idle_inputs();
        rst = 0; freeze = 0; flush = 0; valid_in = 0; s_in = 0;
        wb_en_in = 0; mem_r_en_in = 0; mem_w_en_in = 0;
        alu_res_in = '0; status_bits_in = '0; val_rm_in = '0; dest_in = '0;
    endtask

    initial begin
        // Reset with every input high
        rst = 1; freeze = 1; flush = 1; valid_in = 1; s_in = 1;
        wb_en_in = 1; mem_r_en_in = 1; mem_w_en_in = 1;
        alu_res_in = '1; status_bits_in = '1; val_rm_in = '1; dest_in = '1; cond_in = '1;
        tick();
        tick();
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_alu", alu_res, 32'd0);
        chk("rst_status", 32'(status_reg), 32'd0);
        cond_is(14, 1'b1, "rst_al");
        cond_is(0, 1'b0, "rst_eq");

        // Load with flag update
        idle_inputs();
        valid_in = 1; s_in = 1; wb_en_in = 1; alu_res_in = 32'h0000_0000;
        status_bits_in = 4'b1100; dest_in = 4'd5;
        tick();
        chk("load_alu", alu_res, 32'd0);
        chk("load_wb", 32'(wb_en), 32'd1);
        chk("load_dest", 32'(dest), 32'd5);
        chk("load_status", 32'(status_reg), 32'hC);
        chk("load_carry", 32'(carry), 32'd1);
        cond_is(0, 1'b1, "load_eq");
        cond_is(2, 1'b1, "load_cs");
        cond_is(9, 1'b1, "load_ls");
        cond_is(1, 1'b0, "load_ne");
        cond_is(8, 1'b0, "load_hi");

        // S gating
        s_in = 0; status_bits_in = 4'b0011;
        tick();
        chk("sgate_s0", 32'(status_reg), 32'hC);
        valid_in = 0; s_in = 1;
        tick();
        chk("sgate_inv", 32'(status_reg), 32'hC);
        chk("sgate_wb", 32'(wb_en), 32'd0);

        // Freeze
        valid_in = 1; s_in = 0; alu_res_in = 32'hDEAD_BEEF;
        tick();
        freeze = 1; alu_res_in = 32'h1234_5678; s_in = 1; status_bits_in = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_alu", alu_res, 32'hDEAD_BEEF);
            chk("frz_status", 32'(status_reg), 32'hC);
        end
        freeze = 0;
        tick();
        chk("unfrz_alu", alu_res, 32'h1234_5678);
        chk("unfrz_status", 32'(status_reg), 32'h1);

        // Flush vs freeze: first make the outputs non-zero
        s_in = 0; mem_w_en_in = 1; wb_en_in = 1;
        tick();
        chk("pre_mw", 32'(mem_w_en), 32'd1);
        flush = 1; freeze = 1; s_in = 1; status_bits_in = 4'b0010; alu_res_in = 32'hAAAA_5555;
        tick();
        chk("ffz_mw", 32'(mem_w_en), 32'd1);
        chk("ffz_valid", 32'(valid_out), 32'd1);
        chk("ffz_alu", alu_res, 32'h1234_5678);
        freeze = 0;
        tick();
        chk("fl_mw", 32'(mem_w_en), 32'd0);
        chk("fl_valid", 32'(valid_out), 32'd0);
        chk("fl_status", 32'(status_reg), 32'h1);

        // Signed conditions
        flush = 0; mem_w_en_in = 0; s_in = 1; status_bits_in = 4'b0010;
        tick();
        cond_is(11, 1'b1, "n1v0_lt");
        cond_is(10, 1'b0, "n1v0_ge");
        cond_is(12, 1'b0, "n1v0_gt");
        cond_is(13, 1'b1, "n1v0_le");
        status_bits_in = 4'b0011;
        tick();
        cond_is(10, 1'b1, "n1v1_ge");
        cond_is(11, 1'b0, "n1v1_lt");
        cond_is(12, 1'b1, "n1v1_gt");
        cond_is(13, 1'b0, "n1v1_le");

        // Both memory enables pass through; then reset mid-stall
        mem_r_en_in = 1; mem_w_en_in = 1; dest_in = 4'd9; val_rm_in = 32'hCAFE_F00D;
        tick();
        chk("both_mr", 32'(mem_r_en), 32'd1);
        chk("both_mw", 32'(mem_w_en), 32'd1);
        rst = 1; freeze = 1;
        tick();
        chk("rstfrz_mw", 32'(mem_w_en), 32'd0);
        chk("rstfrz_rm", val_rm, 32'd0);
        chk("rstfrz_status", 32'(status_reg), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rst            = ($urandom_range(0, 31) == 0);
            freeze         = ($urandom_range(0, 3) == 0);
            flush          = ($urandom_range(0, 3) == 0);
            valid_in       = ($urandom_range(0, 3) != 0);
            s_in           = 1'($urandom);
            wb_en_in       = 1'($urandom);
            mem_r_en_in    = 1'($urandom);
            mem_w_en_in    = 1'($urandom);
            alu_res_in     = $urandom;
            val_rm_in      = $urandom;
            status_bits_in = 4'($urandom);
            dest_in        = 4'($urandom);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/exe_mem_stage_reg.md
Name: exe_mem_stage_reg

Overview:
- Sits directly downstream of the execute-stage ALU. Registers the ALU result, store data and control into the EXE/MEM pipeline register.
- Holds the architectural NZCV status register, updated from the ALU flags on S-bit instructions.
- Supplies the carry (for ADC/SBC) and a combinational condition-check result back to the ID/EXE stages.
- Supports pipeline freeze (stall) and flush (kill) with fixed priority.

Parameters:
- DATA_WIDTH, 32, width of ALU result and store data.
- REG_ADDR_WIDTH, 4, width of destination register index.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- freeze  input  1  hold all registers this cycle
- flush  input  1  kill the incoming instruction
- valid_in  input  1  incoming instruction is real
- s_in  input  1  incoming instruction updates flags
- wb_en_in  input  1  write-back enable
- mem_r_en_in  input  1  load enable
- mem_w_en_in  input  1  store enable
- alu_res_in  input  DATA_WIDTH  ALU result
- status_bits_in  input  4  ALU flags, packed {Z,C,N,V}
- val_rm_in  input  DATA_WIDTH  store data
- dest_in  input  REG_ADDR_WIDTH  destination register
- cond_in  input  4  condition field of the instruction in ID
- valid_out  output  1  registered valid
- wb_en  output  1  registered write-back enable
- mem_r_en  output  1  registered load enable
- mem_w_en  output  1  registered store enable
- alu_res  output  DATA_WIDTH  registered ALU result
- val_rm  output  DATA_WIDTH  registered store data
- dest  output  REG_ADDR_WIDTH  registered destination
- status_reg  output  4  NZCV state, packed {Z,C,N,V}
- carry  output  1  status_reg[2], feeds ALU cin
- cond_pass  output  1  combinational result of cond_in evaluated against status_reg

Behaviour:
- The clock and reset are fixed: one clock, `clk`; reset `rst` is synchronous and active-high.
- Priority per rising edge: rst > freeze > flush > normal load.
- Reset: valid_out, wb_en, mem_r_en, mem_w_en = 0; alu_res, val_rm = 0; dest = 0; status_reg = 4'b0000.
- Freeze: every register, including status_reg, holds its value. flush and valid_in are ignored that cycle.
- Flush without freeze:
  - valid_out, wb_en, mem_r_en, mem_w_en load 0.
  - alu_res, val_rm and dest load their inputs; these are don't-care downstream.
  - status_reg holds.
- Normal load:
  - All pipeline outputs load their inputs with 1-cycle latency.
  - Control outputs are ANDed with valid_in, so an invalid bubble never asserts wb_en, mem_r_en or mem_w_en.
- Status update: status_reg <= status_bits_in only when s_in & valid_in & ~flush & ~freeze. Otherwise it holds.
- The new flags are visible to cond_pass and carry the cycle after the S instruction leaves EXE. There is no forwarding inside this block.
- Both mem_r_en_in and mem_w_en_in set in the same cycle: both pass through unchanged. Arbitration is not this block's job.
- cond_pass is purely combinational from cond_in and status_reg (Z = bit 3, C = bit 2, N = bit 1, V = bit 0):
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 0 (reserved)
- Reset asserted mid-stall (rst with freeze): reset wins, and all outputs clear on that edge.

Test Plan:
- Reset: hold rst 2 cycles with all inputs 1.
  -> All outputs 0; status_reg = 0000; cond_pass = 1 for cond_in = 1110 and 0 for 0000.
- Load: valid_in = 1, s_in = 1, wb_en_in = 1, alu_res_in = 32'h0000_0000, status_bits_in = 4'b1100, dest_in = 5.
  -> Next cycle: alu_res = 0, wb_en = 1, dest = 5, status_reg = 1100, carry = 1, cond_pass = 1 for EQ/CS/LS, 0 for NE/HI.
- S gating: valid_in = 1, s_in = 0, status_bits_in = 4'b0011.
  -> status_reg unchanged at 1100.
  -> Then valid_in = 0, s_in = 1, status_bits_in = 4'b0011: status_reg still 1100 and wb_en = 0.
- Freeze: load alu_res_in = 32'hDEAD_BEEF, then freeze = 1 for 3 cycles with alu_res_in = 32'h1234_5678, s_in = 1, status_bits_in = 4'b0001.
  -> alu_res stays DEAD_BEEF and status_reg is unchanged throughout.
  -> On the cycle freeze drops: alu_res = 1234_5678, status_reg = 0001.
- Flush vs freeze: flush = 1 with valid_in = 1, mem_w_en_in = 1, s_in = 1, status_bits_in = 4'b0010.
  -> Next cycle: mem_w_en = 0, valid_out = 0, status_reg unchanged.
  -> Repeat with freeze = 1 as well: all outputs hold their previous values.
- Signed conditions: status_reg = 0010 (N = 1, V = 0) -> LT = 1, GE = 0, GT = 0, LE = 1.
  -> status_reg = 0011 -> GE = 1, LT = 0, GT = 1, LE = 0.
